// File: rtl/breakout_ball_ctrl.sv
// breakout_ball_ctrl
//   Ball sequencer for Breakout. Owns the ball centre, its direction of travel,
//   the serve/play/over game state and the remaining-lives count. The ball is
//   advanced once per video frame (frame_tick), bouncing off the frame walls
//   and the paddle top; passing the bottom costs a life.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   frame_tick          one-cycle pulse per video frame; all stepping happens here
//   launch              serve/restart request (level), only honoured on a tick
//   frame_x/frame_y     frame top-left corner
//   paddle_x/paddle_y   paddle centre
//   ball_x/ball_y       registered ball centre
//   state               0=SERVE 1=PLAY 2=OVER
//   lives               remaining balls
//   hit_paddle          one-cycle pulse on a paddle bounce
//   ball_lost           one-cycle pulse when the ball passes the bottom
//   game_over           high while in OVER
module breakout_ball_ctrl #(
    parameter int FRAME_W     = 275,
    parameter int FRAME_H     = 350,
    parameter int FRAME_THICK = 3,
    parameter int PADDLE_W    = 96,
    parameter int PADDLE_H    = 20,
    parameter int BALL_RADIUS = 8,
    parameter int INIT_VX     = 3,
    parameter int INIT_VY     = 2,
    parameter int LIVES       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [9:0] frame_x,
    input  logic [9:0] frame_y,
    input  logic [9:0] paddle_x,
    input  logic [9:0] paddle_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] state,
    output logic [1:0] lives,
    output logic       hit_paddle,
    output logic       ball_lost,
    output logic       game_over
);

    localparam int PADDLE_R = PADDLE_H / 2;
    localparam int HALF_W   = PADDLE_W / 2;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [1:0] lives_q, lives_d;
    logic       vx_right_q, vx_right_d;
    logic       vy_up_q, vy_up_d;
    logic       hit_q, hit_d;
    logic       lost_q, lost_d;

    // Geometry is evaluated in 12 bits so sums past 1023 never wrap.
    logic [11:0] xmin, xmax, ymin, ymax, ptop, serve_y;
    logic [11:0] bx, by, nx, ny, px, new_x;
    logic        paddle_hit;

    always_comb begin
        xmin    = {2'b0, frame_x} + 12'(FRAME_THICK + BALL_RADIUS);
        xmax    = {2'b0, frame_x} + 12'(FRAME_W - FRAME_THICK - BALL_RADIUS);
        ymin    = {2'b0, frame_y} + 12'(FRAME_THICK + BALL_RADIUS);
        ymax    = {2'b0, frame_y} + 12'(FRAME_H - FRAME_THICK - BALL_RADIUS);
        ptop    = {2'b0, paddle_y} - 12'(PADDLE_R);
        serve_y = ptop - 12'(BALL_RADIUS);
        px      = {2'b0, paddle_x};
        bx      = {2'b0, ball_x_q};
        by      = {2'b0, ball_y_q};
        nx      = vx_right_q ? bx + 12'(INIT_VX) : bx - 12'(INIT_VX);
        ny      = vy_up_q    ? by - 12'(INIT_VY) : by + 12'(INIT_VY);

        // |nx - paddle_x| <= HALF_W written without a subtraction that could go negative.
        paddle_hit = !vy_up_q
                   && (by + 12'(BALL_RADIUS) <  ptop)
                   && (ny + 12'(BALL_RADIUS) >= ptop)
                   && (nx <= px + 12'(HALF_W))
                   && (nx + 12'(HALF_W) >= px);

        // Left test uses the current position so the step never underflows.
        new_x = nx;
        if (!vx_right_q && bx <= xmin + 12'(INIT_VX)) begin
            new_x = xmin;
        end else if (vx_right_q && nx >= xmax) begin
            new_x = xmax;
        end

        state_d    = state_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        lives_d    = lives_q;
        vx_right_d = vx_right_q;
        vy_up_d    = vy_up_q;
        hit_d      = 1'b0;
        lost_d     = 1'b0;

        case (state_q)
            SERVE: begin
                // Ball rides on the paddle every cycle, tick or not.
                ball_x_d = paddle_x;
                ball_y_d = serve_y[9:0];
                if (frame_tick && launch) begin
                    state_d    = PLAY;
                    vx_right_d = 1'b1;
                    vy_up_d    = 1'b1;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    ball_x_d = new_x[9:0];
                    if (!vx_right_q && bx <= xmin + 12'(INIT_VX)) begin
                        vx_right_d = 1'b1;
                    end else if (vx_right_q && nx >= xmax) begin
                        vx_right_d = 1'b0;
                    end

                    // Top, paddle and bottom in that order; paddle wins over bottom.
                    if (vy_up_q && by <= ymin + 12'(INIT_VY)) begin
                        ball_y_d = ymin[9:0];
                        vy_up_d  = 1'b0;
                    end else if (paddle_hit) begin
                        ball_y_d = 10'(ptop - 12'(BALL_RADIUS));
                        vy_up_d  = 1'b1;
                        hit_d    = 1'b1;
                    end else if (ny >= ymax) begin
                        ball_y_d   = ny[9:0];
                        lost_d     = 1'b1;
                        lives_d    = lives_q - 2'd1;
                        state_d    = (lives_q == 2'd1) ? OVER : SERVE;
                        vx_right_d = 1'b1;
                        vy_up_d    = 1'b1;
                    end else begin
                        ball_y_d = ny[9:0];
                    end
                end
            end
            OVER: begin
                if (frame_tick && launch) begin
                    lives_d = 2'(LIVES);
                    state_d = SERVE;
                end
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SERVE;
            ball_x_q   <= '0;
            ball_y_q   <= '0;
            lives_q    <= 2'(LIVES);
            vx_right_q <= 1'b1;
            vy_up_q    <= 1'b1;
            hit_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            lives_q    <= lives_d;
            vx_right_q <= vx_right_d;
            vy_up_q    <= vy_up_d;
            hit_q      <= hit_d;
            lost_q     <= lost_d;
        end
    end

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign state      = state_q;
    assign lives      = lives_q;
    assign hit_paddle = hit_q;
    assign ball_lost  = lost_q;
    assign game_over  = (state_q == OVER);

endmodule
